// File: rtl/sys_defs.sv
// Shared types for the BTB update path: address type, queue entry packet and default sizes.
package sys_defs;

    localparam int N             = 3;
    localparam int BTB_UPD_DEPTH = 8;

    typedef logic [31:0] ADDR;

    typedef struct packed {
        logic valid;
        ADDR  branch_PC;
        ADDR  target_PC;
    } BTB_UPD_PACKET;

endpackage

// File: rtl/btb_upd_merge.sv
// Combinational lane merge: drops same-cycle duplicate PCs (youngest lane wins) and
// matches each surviving lane against the queued entries for in-place coalescing.
module btb_upd_merge
    import sys_defs::*;
#(
    parameter int NUM_LANES = N,
    parameter int DEPTH     = BTB_UPD_DEPTH
) (
    input  logic [NUM_LANES-1:0]       upd_valid,
    input  ADDR                        upd_branch_PC [NUM_LANES],
    input  logic [DEPTH-1:0]           entry_valid,
    input  ADDR                        entry_pc [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   head_ptr,
    input  logic                       pop,
    output logic [NUM_LANES-1:0]       coal_hit,
    output logic [$clog2(DEPTH)-1:0]   coal_idx [NUM_LANES],
    output logic [NUM_LANES-1:0]       alloc_req
);

    localparam int PTR_W = $clog2(DEPTH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic             lane_survive;
            logic             lane_hit;
            logic [PTR_W-1:0] lane_idx;

            always_comb begin
                lane_survive = upd_valid[gi];
                for (int j = gi + 1; j < NUM_LANES; j++) begin
                    if (upd_valid[j] && (upd_branch_PC[j] == upd_branch_PC[gi])) begin
                        lane_survive = 1'b0;
                    end
                end
            end

            // The head being popped this cycle is leaving, so it cannot absorb an update.
            always_comb begin
                lane_hit = 1'b0;
                lane_idx = '0;
                for (int e = DEPTH - 1; e >= 0; e--) begin
                    if (entry_valid[e] && !(pop && (PTR_W'(e) == head_ptr)) &&
                        (entry_pc[e] == upd_branch_PC[gi])) begin
                        lane_hit = 1'b1;
                        lane_idx = PTR_W'(e);
                    end
                end
            end

            assign coal_hit[gi]  = lane_survive && lane_hit;
            assign alloc_req[gi] = lane_survive && !lane_hit;
            assign coal_idx[gi]  = lane_idx;
        end
    endgenerate

endmodule

// File: rtl/btb_update_arbiter.sv
// Funnels multi-lane resolved-branch updates through a coalescing FIFO into the BTB's
// single write port, one update per cycle, with a saturating count of dropped updates.
module btb_update_arbiter
    import sys_defs::*;
#(
    parameter int NUM_LANES  = N,
    parameter int DEPTH      = BTB_UPD_DEPTH,
    parameter int DROP_CNT_W = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_LANES-1:0]     upd_valid,
    input  ADDR                      upd_branch_PC [NUM_LANES],
    input  ADDR                      upd_target_PC [NUM_LANES],
    input  logic                     flush,
    input  logic                     btb_stall,
    output logic                     btb_wr_valid,
    output ADDR                      btb_wr_branch_PC,
    output ADDR                      btb_wr_target_PC,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    BTB_UPD_PACKET          queue_mem [DEPTH];
    logic [PTR_W-1:0]       head_reg;
    logic [PTR_W-1:0]       tail_reg;
    logic [OCC_W-1:0]       occ_reg;
    logic [DROP_CNT_W-1:0]  drop_reg;

    logic                   pop;
    logic [DEPTH-1:0]       entry_valid;
    ADDR                    entry_pc [DEPTH];
    logic [NUM_LANES-1:0]   coal_hit;
    logic [PTR_W-1:0]       coal_idx [NUM_LANES];
    logic [NUM_LANES-1:0]   alloc_req;

    logic [NUM_LANES-1:0]   alloc_en;
    logic [PTR_W-1:0]       alloc_slot [NUM_LANES];
    int                     free_slots;
    int                     alloc_cnt;
    int                     drop_cnt;
    logic [OCC_W-1:0]       occ_next;
    logic [DROP_CNT_W:0]    drop_sum;
    logic [DROP_CNT_W-1:0]  drop_next;

    assign btb_wr_valid     = (occ_reg != '0);
    assign btb_wr_branch_PC = btb_wr_valid ? queue_mem[head_reg].branch_PC : '0;
    assign btb_wr_target_PC = btb_wr_valid ? queue_mem[head_reg].target_PC : '0;
    assign occupancy        = occ_reg;
    assign drop_count       = drop_reg;

    assign pop = btb_wr_valid && !btb_stall;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign entry_valid[gi] = queue_mem[gi].valid;
            assign entry_pc[gi]    = queue_mem[gi].branch_PC;
        end
    endgenerate

    btb_upd_merge #(
        .NUM_LANES (NUM_LANES),
        .DEPTH     (DEPTH)
    ) u_merge (
        .upd_valid     (upd_valid),
        .upd_branch_PC (upd_branch_PC),
        .entry_valid   (entry_valid),
        .entry_pc      (entry_pc),
        .head_ptr      (head_reg),
        .pop           (pop),
        .coal_hit      (coal_hit),
        .coal_idx      (coal_idx),
        .alloc_req     (alloc_req)
    );

    // Lowest lanes take the free slots first; whatever does not fit is dropped.
    always_comb begin
        free_slots = DEPTH - int'(occ_reg) + (pop ? 1 : 0);
        alloc_cnt  = 0;
        drop_cnt   = 0;
        alloc_en   = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            alloc_slot[i] = tail_reg + PTR_W'(alloc_cnt);
            if (alloc_req[i]) begin
                if (alloc_cnt < free_slots) begin
                    alloc_en[i] = 1'b1;
                    alloc_cnt   = alloc_cnt + 1;
                end else begin
                    drop_cnt = drop_cnt + 1;
                end
            end
        end
    end

    always_comb begin
        occ_next  = OCC_W'(int'(occ_reg) - (pop ? 1 : 0) + alloc_cnt);
        drop_sum  = {1'b0, drop_reg} + (DROP_CNT_W + 1)'(drop_cnt);
        drop_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
            drop_reg <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                queue_mem[e] <= '0;
            end
        end else if (flush) begin
            // Incoming lanes are discarded silently; the drop counter survives a flush.
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                queue_mem[e].valid <= 1'b0;
            end
        end else begin
            if (pop) begin
                queue_mem[head_reg].valid <= 1'b0;
                head_reg <= head_reg + PTR_W'(1);
            end
            for (int i = 0; i < NUM_LANES; i++) begin
                if (coal_hit[i]) begin
                    queue_mem[coal_idx[i]].target_PC <= upd_target_PC[i];
                end
                if (alloc_en[i]) begin
                    queue_mem[alloc_slot[i]] <= '{valid: 1'b1,
                                                  branch_PC: upd_branch_PC[i],
                                                  target_PC: upd_target_PC[i]};
                end
            end
            tail_reg <= tail_reg + PTR_W'(alloc_cnt);
            occ_reg  <= occ_next;
            drop_reg <= drop_next;
        end
    end

endmodule

// File: tb/tb_btb_update_arbiter.sv
// Directed test of btb_update_arbiter with three lanes and an eight-entry queue.
module tb_btb_update_arbiter;
    import sys_defs::*;

    localparam int LANES = 3;
    localparam int QD    = 8;
    localparam int DW    = 16;

    logic               clock;
    logic               reset_n;
    logic [LANES-1:0]   upd_valid;
    ADDR                upd_branch_PC [LANES];
    ADDR                upd_target_PC [LANES];
    logic               flush;
    logic               btb_stall;
    logic               btb_wr_valid;
    ADDR                btb_wr_branch_PC;
    ADDR                btb_wr_target_PC;
    logic [3:0]         occupancy;
    logic [DW-1:0]      drop_count;

    int n_checks;
    int n_fail;
    int cycle_no;

    btb_update_arbiter #(
        .NUM_LANES  (LANES),
        .DEPTH      (QD),
        .DROP_CNT_W (DW)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .upd_valid        (upd_valid),
        .upd_branch_PC    (upd_branch_PC),
        .upd_target_PC    (upd_target_PC),
        .flush            (flush),
        .btb_stall        (btb_stall),
        .btb_wr_valid     (btb_wr_valid),
        .btb_wr_branch_PC (btb_wr_branch_PC),
        .btb_wr_target_PC (btb_wr_target_PC),
        .occupancy        (occupancy),
        .drop_count       (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_lanes(input logic [2:0] v,
                             input ADDR p0, input ADDR t0,
                             input ADDR p1, input ADDR t1,
                             input ADDR p2, input ADDR t2);
        upd_valid        = v;
        upd_branch_PC[0] = p0; upd_target_PC[0] = t0;
        upd_branch_PC[1] = p1; upd_target_PC[1] = t1;
        upd_branch_PC[2] = p2; upd_target_PC[2] = t2;
    endtask

    task automatic idle_lanes();
        set_lanes(3'b000, '0, '0, '0, '0, '0, '0);
    endtask

    // One clock transaction; outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
        cycle_no = cycle_no + 1;
        $display("cyc %0d: valid=%0b pc=0x%0h tgt=0x%0h occ=%0d drops=%0d",
                 cycle_no, btb_wr_valid, btb_wr_branch_PC, btb_wr_target_PC,
                 occupancy, drop_count);
    endtask

    task automatic check_out(input string tag, input logic v, input ADDR pc, input ADDR tgt,
                             input int occ, input int drops);
        check_eq({tag, ".valid"}, 64'(btb_wr_valid), 64'(v));
        check_eq({tag, ".pc"},    64'(btb_wr_branch_PC), 64'(pc));
        check_eq({tag, ".tgt"},   64'(btb_wr_target_PC), 64'(tgt));
        check_eq({tag, ".occ"},   64'(occupancy), 64'(occ));
        check_eq({tag, ".drops"}, 64'(drop_count), 64'(drops));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cycle_no  = 0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        btb_stall = 1'b0;
        idle_lanes();

        #12;
        check_out("reset", 1'b0, 32'h0, 32'h0, 0, 0);
        reset_n = 1'b1;

        // Single update: visible for exactly one cycle.
        set_lanes(3'b001, 32'h100, 32'h200, '0, '0, '0, '0);
        step();
        idle_lanes();
        check_out("t1.out", 1'b1, 32'h100, 32'h200, 1, 0);
        step();
        check_out("t1.drain", 1'b0, 32'h0, 32'h0, 0, 0);

        // Same-cycle duplicate: higher lane wins, not a drop.
        set_lanes(3'b011, 32'h140, 32'h300, 32'h140, 32'h340, '0, '0);
        step();
        idle_lanes();
        check_out("t2.merge", 1'b1, 32'h140, 32'h340, 1, 0);
        step();
        check_eq("t2.drain.occ", 64'(occupancy), 64'd0);

        // Coalesce into the stalled head.
        btb_stall = 1'b1;
        set_lanes(3'b001, 32'h100, 32'h200, '0, '0, '0, '0);
        step();
        check_out("t3.fill", 1'b1, 32'h100, 32'h200, 1, 0);
        set_lanes(3'b001, 32'h100, 32'h280, '0, '0, '0, '0);
        step();
        idle_lanes();
        check_out("t3.coal", 1'b1, 32'h100, 32'h280, 1, 0);
        btb_stall = 1'b0;
        step();
        check_out("t3.drain", 1'b0, 32'h0, 32'h0, 0, 0);

        // Fill while stalled: third cycle overflows by one, highest lane dropped.
        btb_stall = 1'b1;
        set_lanes(3'b111, 32'h1000, 32'h5000, 32'h1004, 32'h5004, 32'h1008, 32'h5008);
        step();
        check_eq("t4.occ3", 64'(occupancy), 64'd3);
        set_lanes(3'b111, 32'h1010, 32'h5010, 32'h1014, 32'h5014, 32'h1018, 32'h5018);
        step();
        check_eq("t4.occ6", 64'(occupancy), 64'd6);
        set_lanes(3'b111, 32'h1020, 32'h5020, 32'h1024, 32'h5024, 32'h1028, 32'h5028);
        step();
        check_out("t4.full", 1'b1, 32'h1000, 32'h5000, 8, 1);

        // Full with pop: one slot frees, second new lane is dropped.
        btb_stall = 1'b0;
        set_lanes(3'b011, 32'h2000, 32'h6000, 32'h2004, 32'h6004, '0, '0);
        step();
        idle_lanes();
        check_out("t5.fullpop", 1'b1, 32'h1004, 32'h5004, 8, 2);

        for (int k = 0; k < 3; k++) step();
        check_out("t6.occ5", 1'b1, 32'h1014, 32'h5014, 5, 2);

        // Flush with incoming updates: output still valid this cycle, nothing counted.
        flush = 1'b1;
        set_lanes(3'b011, 32'h3000, 32'h7000, 32'h3004, 32'h7004, '0, '0);
        #1;
        check_eq("t6.flush.valid_now", 64'(btb_wr_valid), 64'd1);
        step();
        flush = 1'b0;
        idle_lanes();
        check_out("t6.flushed", 1'b0, 32'h0, 32'h0, 0, 2);

        // Head being popped must not absorb a matching update.
        set_lanes(3'b001, 32'h100, 32'h111, '0, '0, '0, '0);
        step();
        check_out("t7.first", 1'b1, 32'h100, 32'h111, 1, 2);
        set_lanes(3'b001, 32'h100, 32'h3AA, '0, '0, '0, '0);
        step();
        idle_lanes();
        check_out("t7.realloc", 1'b1, 32'h100, 32'h3AA, 1, 2);
        step();
        check_eq("t7.drain.occ", 64'(occupancy), 64'd0);

        // Asynchronous reset between clock edges.
        btb_stall = 1'b1;
        set_lanes(3'b001, 32'h500, 32'h600, '0, '0, '0, '0);
        step();
        idle_lanes();
        check_eq("t8.pre.occ", 64'(occupancy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("t8.async", 1'b0, 32'h0, 32'h0, 0, 0);
        @(negedge clock);
        reset_n   = 1'b1;
        btb_stall = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
